// File: rtl/sort_sequencer.sv
// Iterative ascending sorter: one odd-even transposition pass per clock over a
// shared bank of compare-exchange cells, with valid/ready on both sides.
module sort_sequencer #(
    parameter int DIM        = 8,
    parameter int N          = 8,
    parameter int EARLY_EXIT = 1,
    parameter int PW         = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIM*N-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIM*N-1:0]  out_data,
    output logic              busy,
    output logic [PW-1:0]     pass_count
);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t          state;
    logic [N-1:0]    elem      [DIM];
    logic [N-1:0]    pass_elem [DIM];
    logic            pass_swapped;
    logic            prev_clean;
    logic            last_pass;

    assign in_ready = (state == IDLE);

    for (genvar g = 0; g < DIM; g++) begin : g_out
        assign out_data[g*N +: N] = elem[g];
    end

    // The parity of pass_count selects which neighbour pairs are compared;
    // pairs never overlap, so every cell reads the pre-pass array.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit -- no latches.
        pass_elem    = elem;
        pass_swapped = 1'b0;
        for (int i = 0; i < DIM - 1; i++) begin
            if ((i % 2) == int'(pass_count[0])) begin
                if (elem[i] > elem[i+1]) begin
                    pass_elem[i]   = elem[i+1];
                    pass_elem[i+1] = elem[i];
                    pass_swapped   = 1'b1;
                end
            end
        end
    end

    // Two consecutive clean passes prove the array sorted; DIM passes always do.
    assign last_pass = (pass_count == PW'(DIM - 1)) ||
                       ((EARLY_EXIT != 0) && (pass_count != '0) &&
                        prev_clean && !pass_swapped);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            pass_count <= '0;
            prev_clean <= 1'b0;
            // NOTE: the element array is cleared because it drives out_data.
            for (int i = 0; i < DIM; i++) elem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < DIM; i++) elem[i] <= in_data[i*N +: N];
                        pass_count <= '0;
                        prev_clean <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SORT;
                    end
                end
                SORT: begin
                    elem       <= pass_elem;
                    pass_count <= pass_count + 1'b1;
                    prev_clean <= !pass_swapped;
                    if (last_pass) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed and randomised checks of sort_sequencer with DIM=4, N=8, one
// instance per EARLY_EXIT setting sharing clock, reset and input data.
module tb_sort_sequencer;

    localparam int DIM = 4;
    localparam int N   = 8;
    localparam int W   = DIM * N;
    localparam int PW  = 7;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [W-1:0]           in_data;
    logic [1:0]             in_valid;
    logic [1:0]             in_ready;
    logic [1:0]             out_valid;
    logic [1:0]             out_ready;
    logic [1:0]             busy;
    logic [1:0][W-1:0]      out_data;
    logic [1:0][PW-1:0]     pass_count;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sort_sequencer #(.DIM(DIM), .N(N), .EARLY_EXIT(0), .PW(PW)) u_ee0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0]), .pass_count(pass_count[0])
    );

    sort_sequencer #(.DIM(DIM), .N(N), .EARLY_EXIT(1), .PW(PW)) u_ee1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1]), .pass_count(pass_count[1])
    );

    function automatic logic [W-1:0] pack(input int a0, input int a1, input int a2, input int a3);
        return {N'(a3), N'(a2), N'(a1), N'(a0)};
    endfunction

    // Reference: plain insertion sort, ascending.
    function automatic logic [W-1:0] ref_sort(input logic [W-1:0] v);
        logic [N-1:0] e [DIM];
        logic [N-1:0] key;
        logic [W-1:0] r;
        int j;
        for (int i = 0; i < DIM; i++) e[i] = v[i*N +: N];
        for (int i = 1; i < DIM; i++) begin
            key = e[i];
            j = i - 1;
            while (j >= 0 && e[j] > key) begin
                e[j+1] = e[j];
                j--;
            end
            e[j+1] = key;
        end
        for (int i = 0; i < DIM; i++) r[i*N +: N] = e[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one vector to instance sel and drains the result. exp_passes < 0
    // means only the 2..DIM bound is known. full adds handshake and hold checks.
    task automatic run_vec(input int sel, input logic [W-1:0] vec, input logic [W-1:0] exp_data,
                           input int exp_passes, input int hold, input bit full, input string tag);
        int n;
        int lat;
        logic [W-1:0] junk;
        in_data       = vec;
        in_valid[sel] = 1'b1;
        n = 0;
        while (!in_ready[sel] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check({tag, "_accept_timeout"}, 0, 1);
        tick();
        in_valid[sel] = 1'b0;
        in_data       = ~vec;
        if (full) begin
            check({tag, "_busy_after_accept"}, busy[sel], 1);
            check({tag, "_in_ready_in_sort"}, in_ready[sel], 0);
        end
        lat = 0;
        while (!out_valid[sel] && lat < 200) begin
            tick();
            lat++;
        end
        if (lat >= 200) check({tag, "_done_timeout"}, 0, 1);
        check({tag, "_data"}, out_data[sel], exp_data);
        if (exp_passes >= 0) begin
            check({tag, "_pass_count"}, pass_count[sel], exp_passes);
            check({tag, "_latency"}, lat, exp_passes);
        end else begin
            check({tag, "_pass_le_dim"}, pass_count[sel] <= PW'(DIM), 1);
            check({tag, "_pass_ge_2"}, pass_count[sel] >= PW'(2), 1);
        end
        if (full) begin
            check({tag, "_busy_done"}, busy[sel], 0);
            check({tag, "_in_ready_done"}, in_ready[sel], 0);
        end
        // Backpressure: output must hold and a new offer must be ignored.
        if (hold > 0) begin
            junk = W'($urandom());
            in_data       = junk;
            in_valid[sel] = 1'b1;
            for (int c = 0; c < hold; c++) begin
                tick();
                if (full) begin
                    check({tag, "_hold_valid"}, out_valid[sel], 1);
                    check({tag, "_hold_data"}, out_data[sel], exp_data);
                    check({tag, "_hold_in_ready"}, in_ready[sel], 0);
                end
            end
            in_valid[sel] = 1'b0;
            if (full && exp_passes >= 0) check({tag, "_hold_pass_count"}, pass_count[sel], exp_passes);
        end
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
        check({tag, "_valid_drop"}, out_valid[sel], 0);
        if (full) begin
            check({tag, "_in_ready_after"}, in_ready[sel], 1);
            check({tag, "_data_kept"}, out_data[sel], exp_data);
        end
    endtask

    initial begin
        logic [W-1:0] v;
        int sel;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        in_data   = pack(11, 22, 33, 44);
        repeat (2) tick();
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            check("reset_in_ready", in_ready[s], 1);
            check("reset_out_valid", out_valid[s], 0);
            check("reset_busy", busy[s], 0);
            check("reset_pass_count", pass_count[s], 0);
            check("reset_out_data", out_data[s], 0);
        end

        // Fixed-length sort
        run_vec(0, pack(9, 3, 7, 1), pack(1, 3, 7, 9), 4, 0, 1, "ee0_basic");
        run_vec(0, pack(255, 0, 255, 0), pack(0, 0, 255, 255), 4, 0, 1, "ee0_extremes");
        run_vec(0, pack(1, 2, 3, 4), pack(1, 2, 3, 4), 4, 0, 1, "ee0_sorted");

        // Early exit
        run_vec(1, pack(1, 2, 3, 4), pack(1, 2, 3, 4), 2, 0, 1, "ee1_sorted");
        run_vec(1, pack(4, 3, 2, 1), pack(1, 2, 3, 4), 4, 0, 1, "ee1_reverse");
        run_vec(1, pack(5, 5, 5, 5), pack(5, 5, 5, 5), 2, 0, 1, "ee1_all_equal");
        run_vec(1, pack(255, 0, 255, 0), pack(0, 0, 255, 255), 4, 0, 1, "ee1_extremes");
        run_vec(1, pack(2, 1, 3, 4), pack(1, 2, 3, 4), 3, 0, 1, "ee1_one_swap");
        run_vec(1, pack(1, 3, 2, 4), pack(1, 2, 3, 4), 4, 0, 1, "ee1_clean_then_swap");

        // Backpressure for 10 cycles in DONE
        run_vec(0, pack(200, 100, 50, 25), pack(25, 50, 100, 200), 4, 10, 1, "ee0_backpressure");

        // Reset after two passes
        in_data     = pack(9, 3, 7, 1);
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        check("midsort_busy", busy[0], 1);
        check("midsort_pass_count", pass_count[0], 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_in_ready", in_ready[0], 1);
        check("rst_mid_out_valid", out_valid[0], 0);
        check("rst_mid_busy", busy[0], 0);
        check("rst_mid_pass_count", pass_count[0], 0);
        check("rst_mid_out_data", out_data[0], 0);
        run_vec(0, pack(40, 30, 20, 10), pack(10, 20, 30, 40), 4, 0, 1, "ee0_after_reset");

        // Randomised vectors with random gaps, alternating instances
        for (int k = 0; k < 1000; k++) begin
            sel = k % 2;
            for (int i = 0; i < DIM; i++)
                v[i*N +: N] = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 3)) : N'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) tick();
            run_vec(sel, v, ref_sort(v), (sel == 0) ? DIM : -1, int'($urandom_range(0, 3)), 0,
                    (sel == 0) ? "rand_ee0" : "rand_ee1");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
